// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter in front of the register file's single write port.
// Two producers, the ALU (a_*) and the load/store unit (m_*), hand completed
// results over through valid/ready handshakes. Each source has its own small
// FIFO. Each cycle at most one FIFO head is granted onto the registered
// wen/waddr/wdata port. The LSU normally wins a contested cycle. After
// STARVE_MAX consecutive ALU losses, the ALU is forced through instead.
// pend_mask tells the decode/hazard logic which registers still have a
// queued write in flight.
//
// Parameters
//   XLEN        data width
//   AW          register address width
//   DEPTH       entries per source FIFO (power of two, >= 2)
//   STARVE_MAX  consecutive ALU losses before the ALU is forced a grant
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low (asserted when 0)
//   a_valid    in   ALU result valid
//   a_ready    out  ALU FIFO can accept (0 while in reset)
//   a_rd       in   ALU destination register
//   a_data     in   ALU result
//   m_valid    in   LSU result valid
//   m_ready    out  LSU FIFO can accept (0 while in reset)
//   m_rd       in   LSU destination register
//   m_data     in   LSU result
//   wen        out  register file write enable (registered)
//   waddr      out  register file write address (registered)
//   wdata      out  register file write data (registered)
//   pend_mask  out  bit r set while any queued entry targets register r
// ---------------------------------------------------------------------------
module wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int AW         = 5,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [AW-1:0]        a_rd,
   input  logic [XLEN-1:0]      a_data,
   input  logic                 m_valid,
   output logic                 m_ready,
   input  logic [AW-1:0]        m_rd,
   input  logic [XLEN-1:0]      m_data,
   output logic                 wen,
   output logic [AW-1:0]        waddr,
   output logic [XLEN-1:0]      wdata,
   output logic [(1<<AW)-1:0]   pend_mask
);

   // Source indices into the per-source arrays below.
   localparam int SRC_A = 0;
   localparam int SRC_M = 1;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [1:0]       in_valid;
   logic [AW-1:0]    in_rd      [2];
   logic [XLEN-1:0]  in_data    [2];

   logic [1:0]       in_ready;
   logic [1:0]       do_push;
   logic [1:0]       head_valid;
   logic [1:0]       grant;

   logic [AW-1:0]    rd_mem     [2][DEPTH];
   logic [XLEN-1:0]  data_mem   [2][DEPTH];
   logic [PW-1:0]    wr_ptr     [2];
   logic [PW-1:0]    rd_ptr     [2];
   logic [CW-1:0]    count      [2];

   logic [AW-1:0]    head_rd    [2];
   logic [XLEN-1:0]  head_data  [2];

   logic [SW-1:0]    starve_cnt;
   logic [SW-1:0]    starve_next;

   logic             any_grant;
   logic [AW-1:0]    sel_rd;
   logic [XLEN-1:0]  sel_data;

   assign in_valid       = {m_valid, a_valid};
   assign in_rd[SRC_A]   = a_rd;
   assign in_rd[SRC_M]   = m_rd;
   assign in_data[SRC_A] = a_data;
   assign in_data[SRC_M] = m_data;

   assign a_ready = in_ready[SRC_A];
   assign m_ready = in_ready[SRC_M];

   // FIFO status and head view. Ready depends only on the current count, so
   // a pop in the same cycle never makes room for a push into a full FIFO.
   // Gating with rst keeps both producers stalled while reset is asserted.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         in_ready[s]   = rst && (count[s] != FULL_CNT);
         do_push[s]    = in_valid[s] && in_ready[s];
         head_valid[s] = (count[s] != '0);
         head_rd[s]    = rd_mem[s][rd_ptr[s]];
         head_data[s]  = data_mem[s][rd_ptr[s]];
      end
   end

   // Arbitration over the two heads: a lone head always wins. When both are
   // present the LSU wins, unless the ALU has already lost STARVE_MAX times
   // in a row.
   always_comb begin
      grant        = 2'b00;
      grant[SRC_A] = head_valid[SRC_A] &&
                     (!head_valid[SRC_M] || (starve_cnt == STARVE_LIM));
      grant[SRC_M] = head_valid[SRC_M] && !grant[SRC_A];
      any_grant    = grant[SRC_A] || grant[SRC_M];
      sel_rd       = grant[SRC_A] ? head_rd[SRC_A]   : head_rd[SRC_M];
      sel_data     = grant[SRC_A] ? head_data[SRC_A] : head_data[SRC_M];
   end

   // Starvation counter: it tracks only a waiting ALU head that keeps losing.
   // An empty ALU FIFO or an ALU grant restarts it. It saturates so that the
   // forced-grant compare above stays true until the ALU gets through.
   always_comb begin
      starve_next = starve_cnt;
      if (!head_valid[SRC_A] || grant[SRC_A]) begin
         starve_next = '0;
      end else if (grant[SRC_M] && (starve_cnt != STARVE_LIM)) begin
         starve_next = starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_next;
      end
   end

   // FIFO pointers and occupancy for both sources. Pointers are exactly
   // log2(DEPTH) bits wide, so they wrap modulo DEPTH by themselves. The
   // count needs the extra bit to represent a full FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < 2; s++) begin
            wr_ptr[s] <= '0;
            rd_ptr[s] <= '0;
            count[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (do_push[s]) begin
               wr_ptr[s] <= wr_ptr[s] + 1'b1;
            end
            if (grant[s]) begin
               rd_ptr[s] <= rd_ptr[s] + 1'b1;
            end
            case ({do_push[s], grant[s]})
               2'b10:   count[s] <= count[s] + 1'b1;
               2'b01:   count[s] <= count[s] - 1'b1;
               default: count[s] <= count[s];
            endcase
         end
      end
   end

   // Entry storage. No reset is needed: an entry is only observed while the
   // count says it is live, and reset clears the count.
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (do_push[s]) begin
            rd_mem[s][wr_ptr[s]]   <= in_rd[s];
            data_mem[s][wr_ptr[s]] <= in_data[s];
         end
      end
   end

   // Registered write port. A granted entry targeting x0 is consumed, and its
   // address and data still load, but it never raises the write enable.
   // Without a grant the enable drops and the address and data hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wen   <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else if (any_grant) begin
         wen   <= (sel_rd != '0);
         waddr <= sel_rd;
         wdata <= sel_data;
      end else begin
         wen   <= 1'b0;
      end
   end

   // Pending-write mask: a slot is live when its distance from the read
   // pointer (mod DEPTH) is below the count. A popped entry therefore drops
   // out of the mask in the same cycle its wen is visible. Register 0 is
   // never reported because writes to it are discarded.
   always_comb begin
      pend_mask = '0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(PW'(PW'(i) - rd_ptr[s])) < count[s]) begin
               pend_mask[rd_mem[s][i]] = 1'b1;
            end
         end
      end
      pend_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed bench for wb_arbiter. Expected register-file writes are queued in
// the order the arbitration rules dictate when each scenario is driven.
// A negedge monitor pops one expectation for every wen pulse. Point checks on
// readies, pend_mask, the starvation counter and reset behaviour are made
// inline in the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

   localparam int XLEN       = 32;
   localparam int AW         = 5;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wr_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                a_valid;
   logic                a_ready;
   logic [AW-1:0]       a_rd;
   logic [XLEN-1:0]     a_data;
   logic                m_valid;
   logic                m_ready;
   logic [AW-1:0]       m_rd;
   logic [XLEN-1:0]     m_data;
   logic                wen;
   logic [AW-1:0]       waddr;
   logic [XLEN-1:0]     wdata;
   logic [(1<<AW)-1:0]  pend_mask;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;

   wb_arbiter #(
      .XLEN      (XLEN),
      .AW        (AW),
      .DEPTH     (DEPTH),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_rd     (a_rd),
      .a_data   (a_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_rd     (m_rd),
      .m_data   (m_data),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .pend_mask(pend_mask)
   );

   always #5 clk = ~clk;

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Drives both producer interfaces. Called at a negedge, so the values are
   // stable well before the next rising edge.
   task automatic applyStimulus(input logic av, input logic [AW-1:0] ard,
                                input logic [XLEN-1:0] adata,
                                input logic mv, input logic [AW-1:0] mrd,
                                input logic [XLEN-1:0] mdata);
      a_valid = av;
      a_rd    = ard;
      a_data  = adata;
      m_valid = mv;
      m_rd    = mrd;
      m_data  = mdata;
   endtask

   // Scoreboard side: every write seen on the port must be the next one
   // expected.
   always @(negedge clk) begin
      if (rst === 1'b1 && wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected_write", {63'd0, wen}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("sb_waddr", {59'd0, waddr}, {59'd0, mon_e.rd});
            checkOutput("sb_wdata", {32'd0, wdata}, {32'd0, mon_e.data});
         end
      end
   end

   initial begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      // Reset state
      checkOutput("rst_wen",     {63'd0, wen}, 64'd0);
      checkOutput("rst_waddr",   {59'd0, waddr}, 64'd0);
      checkOutput("rst_wdata",   {32'd0, wdata}, 64'd0);
      checkOutput("rst_pend",    {32'd0, pend_mask}, 64'd0);
      checkOutput("rst_a_ready", {63'd0, a_ready}, 64'd0);
      checkOutput("rst_m_ready", {63'd0, m_ready}, 64'd0);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rel_a_ready", {63'd0, a_ready}, 64'd1);
      checkOutput("rel_m_ready", {63'd0, m_ready}, 64'd1);

      // Single ALU push
      exp_q.push_back('{rd: 5'd1, data: 32'hdeadbeef});
      applyStimulus(1'b1, 5'd1, 32'hdeadbeef, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("t1_pend_set",  {32'd0, pend_mask}, 64'h2);
      checkOutput("t1_wen_early", {63'd0, wen}, 64'd0);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("t1_wen",       {63'd0, wen}, 64'd1);
      checkOutput("t1_waddr",     {59'd0, waddr}, 64'd1);
      checkOutput("t1_wdata",     {32'd0, wdata}, 64'hdeadbeef);
      checkOutput("t1_pend_clr",  {32'd0, pend_mask}, 64'd0);
      @(negedge clk);
      checkOutput("t1_wen_drop",  {63'd0, wen}, 64'd0);

      // Simultaneous pushes: LSU first, ALU next
      exp_q.push_back('{rd: 5'd3, data: 32'hcafed00d});
      exp_q.push_back('{rd: 5'd2, data: 32'hbaadcafe});
      applyStimulus(1'b1, 5'd2, 32'hbaadcafe, 1'b1, 5'd3, 32'hcafed00d);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("t2_pend",   {32'd0, pend_mask}, 64'h0000000c);
      @(negedge clk);
      checkOutput("t2_wen0",   {63'd0, wen}, 64'd1);
      checkOutput("t2_waddr0", {59'd0, waddr}, 64'd3);
      @(negedge clk);
      checkOutput("t2_wen1",   {63'd0, wen}, 64'd1);
      checkOutput("t2_waddr1", {59'd0, waddr}, 64'd2);
      @(negedge clk);
      checkOutput("t2_wen_end", {63'd0, wen}, 64'd0);

      // LSU streams against one ALU entry: ALU forced on 5th contest
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{rd: AW'(8 + i), data: 32'h10000000 + i});
      end
      exp_q.push_back('{rd: 5'd4, data: 32'h8badf00d});
      exp_q.push_back('{rd: 5'd12, data: 32'h10000004});
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i == 0, 5'd4, 32'h8badf00d,
                       1'b1, AW'(8 + i), 32'h10000000 + i);
         @(negedge clk);
      end
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("t3_starve_sat", {61'd0, dut.starve_cnt}, 64'd4);
      checkOutput("t3_waddr_m3",   {59'd0, waddr}, 64'd11);
      @(negedge clk);
      checkOutput("t3_waddr_alu",  {59'd0, waddr}, 64'd4);
      checkOutput("t3_wdata_alu",  {32'd0, wdata}, 64'h8badf00d);
      checkOutput("t3_starve_clr", {61'd0, dut.starve_cnt}, 64'd0);
      @(negedge clk);
      checkOutput("t3_waddr_m4",   {59'd0, waddr}, 64'd12);
      checkOutput("t3_starve_idle", {61'd0, dut.starve_cnt}, 64'd0);
      @(negedge clk);
      checkOutput("t3_wen_end",    {63'd0, wen}, 64'd0);

      // Write to x0 from the LSU: consumed silently
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'hb105f00d);
      @(negedge clk);
      checkOutput("t4_pend_q",  {32'd0, pend_mask}, 64'd0);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("t4_wen",     {63'd0, wen}, 64'd0);
      checkOutput("t4_waddr",   {59'd0, waddr}, 64'd0);
      checkOutput("t4_wdata",   {32'd0, wdata}, 64'hb105f00d);
      checkOutput("t4_pend",    {32'd0, pend_mask}, 64'd0);

      // Fill the ALU FIFO while the LSU keeps winning
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{rd: AW'(24 + i), data: 32'hb0000000 + i});
      end
      exp_q.push_back('{rd: 5'd16, data: 32'ha0000000});
      exp_q.push_back('{rd: 5'd28, data: 32'hb0000004});
      exp_q.push_back('{rd: 5'd17, data: 32'ha0000001});
      exp_q.push_back('{rd: 5'd18, data: 32'ha0000002});
      checkOutput("t5_ready_d0", {63'd0, a_ready}, 64'd1);
      applyStimulus(1'b1, 5'd16, 32'ha0000000, 1'b1, 5'd24, 32'hb0000000);
      @(negedge clk);
      checkOutput("t5_ready_d1", {63'd0, a_ready}, 64'd1);
      applyStimulus(1'b1, 5'd17, 32'ha0000001, 1'b1, 5'd25, 32'hb0000001);
      for (int i = 2; i < 5; i++) begin
         @(negedge clk);
         checkOutput("t5_a_full", {63'd0, a_ready}, 64'd0);
         applyStimulus(1'b1, 5'd18, 32'ha0000002,
                       1'b1, AW'(24 + i), 32'hb0000000 + i);
      end
      @(negedge clk);
      checkOutput("t5_a_full_d5", {63'd0, a_ready}, 64'd0);
      applyStimulus(1'b1, 5'd18, 32'ha0000002, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("t5_ready_back", {63'd0, a_ready}, 64'd1);
      checkOutput("t5_waddr_a0",   {59'd0, waddr}, 64'd16);
      @(negedge clk);
      checkOutput("t5_refull",     {63'd0, a_ready}, 64'd0);
      checkOutput("t5_waddr_m4",   {59'd0, waddr}, 64'd28);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("t5_waddr_a1",   {59'd0, waddr}, 64'd17);
      checkOutput("t5_ready_d8",   {63'd0, a_ready}, 64'd1);
      @(negedge clk);
      checkOutput("t5_waddr_a2",   {59'd0, waddr}, 64'd18);
      @(negedge clk);
      checkOutput("t5_wen_end",    {63'd0, wen}, 64'd0);

      // Reset asserted mid-stream with both FIFOs occupied
      exp_q.push_back('{rd: 5'd21, data: 32'hc0000001});
      applyStimulus(1'b1, 5'd20, 32'hc0000000, 1'b1, 5'd21, 32'hc0000001);
      @(negedge clk);
      applyStimulus(1'b1, 5'd22, 32'hc0000002, 1'b1, 5'd23, 32'hc0000003);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("t6_wen_pre",  {63'd0, wen}, 64'd1);
      checkOutput("t6_pend_pre", {32'd0, pend_mask}, 64'h00d00000);
      #2 rst = 1'b0;
      #1;
      checkOutput("t6_wen_rst",     {63'd0, wen}, 64'd0);
      checkOutput("t6_pend_rst",    {32'd0, pend_mask}, 64'd0);
      checkOutput("t6_a_ready_rst", {63'd0, a_ready}, 64'd0);
      checkOutput("t6_m_ready_rst", {63'd0, m_ready}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t6_no_stale_wen", {63'd0, wen}, 64'd0);
         checkOutput("t6_pend_after",   {32'd0, pend_mask}, 64'd0);
      end
      checkOutput("t6_a_ready_after", {63'd0, a_ready}, 64'd1);
      checkOutput("t6_m_ready_after", {63'd0, m_ready}, 64'd1);

      checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
